collatz_range_multi: RTL and testbench

Multi-lane Collatz range tester. After `go`, it computes the Collatz term count for `RAM_WORDS` consecutive start values and stores the counts in an internal RAM. `LANES` iterator lanes work in parallel, and a separate registered read port exposes the results. It is the parametrised next generation of the single-iterator range block and sits between the host register interface and the Collatz iterator lanes.

---
 rtl/collatz_range_multi_pkg.sv | 23 ++
 rtl/collatz_range_multi_if.sv | 21 ++
 rtl/collatz_range_multi_lane.sv | 88 ++++++++
 rtl/collatz_range_multi.sv | 145 ++++++++++++++
 tb/tb_collatz_range_multi.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/collatz_range_multi_pkg.sv
// Shared types and constants for the multi-lane Collatz range tester.
//   top_state_e  : run controller states
//   lane_state_e : per-lane iterator states
//   OVF_SENTINEL : all-ones, sliced to COUNT_WIDTH; marks an overflowed value
//   COUNT_MIN    : count(0) = count(1) = 1, also the counter start value
package collatz_pkg;

  typedef enum logic [1:0] {
    TOP_IDLE   = 2'd0,
    TOP_RUN    = 2'd1,
    TOP_FINISH = 2'd2
  } top_state_e;

  typedef enum logic [1:0] {
    LANE_IDLE = 2'd0,
    LANE_ITER = 2'd1,
    LANE_HOLD = 2'd2
  } lane_state_e;

  localparam logic [63:0] OVF_SENTINEL = '1;
  localparam logic [63:0] COUNT_MIN    = 64'd1;

endpackage

// File: rtl/collatz_range_multi_if.sv
// Host-side bus of the Collatz range tester.
//   go/start : run request and first value
//   raddr    : result read address; rdata returns one cycle later
//   busy/done/ovf : run status
// master = host, slave = range tester.
interface collatz_range_multi_if #(
  parameter int N_WIDTH       = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int RAM_ADDR_BITS = 4
) ();
  logic                     go;
  logic [N_WIDTH-1:0]       start;
  logic [RAM_ADDR_BITS-1:0] raddr;
  logic [COUNT_WIDTH-1:0]   rdata;
  logic                     busy;
  logic                     done;
  logic                     ovf;

  modport master (output go, start, raddr, input rdata, busy, done, ovf);
  modport slave  (input go, start, raddr, output rdata, busy, done, ovf);
endinterface

// File: rtl/collatz_range_multi_lane.sv
// One Collatz iterator lane: loads a value, steps it to 1 counting terms,
// then holds its result until the write arbiter grants it.
//   load/n/idx      : start a new value tagged with its RAM index
//   grant           : result accepted, lane returns to idle
//   hold            : result ready
//   result/idx_out  : term count (or overflow sentinel) and its RAM index
//   lane_ovf        : held result is an overflow
//
// state     | meaning
// LANE_IDLE | free, waiting for a load
// LANE_ITER | one Collatz step per cycle
// LANE_HOLD | result frozen until granted
module collatz_lane
  import collatz_pkg::*;
#(
  parameter int N_WIDTH     = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [N_WIDTH-1:0]     n,
  input  logic [IDX_WIDTH-1:0]   idx,
  input  logic                   grant,
  output logic                   hold,
  output logic [COUNT_WIDTH-1:0] result,
  output logic [IDX_WIDTH-1:0]   idx_out,
  output logic                   lane_ovf
);
  localparam logic [COUNT_WIDTH-1:0] SENT  = OVF_SENTINEL[COUNT_WIDTH-1:0];
  localparam logic [COUNT_WIDTH-1:0] CSTART = COUNT_MIN[COUNT_WIDTH-1:0];
  localparam logic [N_WIDTH-1:0]     ONE_N  = N_WIDTH'(1);

  lane_state_e            state_q;
  logic [N_WIDTH-1:0]     n_q, n_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [IDX_WIDTH-1:0]   idx_q;
  logic                   ovf_q;
  logic [N_WIDTH+1:0]     triple;
  logic                   step_ovf;

  // 3n+1 in two extra bits so overflow past N_WIDTH is visible
  always_comb begin
    triple   = {2'b00, n_q} + {1'b0, n_q, 1'b0} + (N_WIDTH+2)'(1);
    step_ovf = n_q[0] && (triple[N_WIDTH+1:N_WIDTH] != 2'b00);
    n_d      = n_q[0] ? triple[N_WIDTH-1:0] : {1'b0, n_q[N_WIDTH-1:1]};
    // all-ones is kept free for the overflow sentinel
    count_d  = (count_q == SENT - 1'b1) ? count_q : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LANE_IDLE;
      n_q     <= '0;
      count_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        LANE_IDLE: if (load) begin
          n_q     <= n;
          idx_q   <= idx;
          count_q <= CSTART;
          ovf_q   <= 1'b0;
          state_q <= (n <= ONE_N) ? LANE_HOLD : LANE_ITER;
        end
        LANE_ITER: begin
          if (step_ovf) begin
            ovf_q   <= 1'b1;
            state_q <= LANE_HOLD;
          end else begin
            n_q     <= n_d;
            count_q <= count_d;
            if (n_d <= ONE_N) state_q <= LANE_HOLD;
          end
        end
        LANE_HOLD: if (grant) state_q <= LANE_IDLE;
        default:   state_q <= LANE_IDLE;
      endcase
    end
  end

  assign hold     = (state_q == LANE_HOLD);
  assign result   = ovf_q ? SENT : count_q;
  assign idx_out  = idx_q;
  assign lane_ovf = ovf_q;
endmodule

// File: rtl/collatz_range_multi.sv
// Multi-lane Collatz range tester: on go, computes term counts for RAM_WORDS
// consecutive values with LANES parallel iterators and stores them in a RAM
// exposed through a registered read port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : go/start request, raddr/rdata read port, busy/done/ovf status
//
// state      | meaning
// TOP_IDLE   | waiting for go
// TOP_RUN    | dispatching values to lanes and writing results
// TOP_FINISH | done pulse; go accepted here as in idle
module collatz_range_multi
  import collatz_pkg::*;
#(
  parameter int N_WIDTH       = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int RAM_WORDS     = 16,
  parameter int RAM_ADDR_BITS = 4,
  parameter int LANES         = 2
) (
  input logic                 clk,
  input logic                 reset,
  collatz_range_multi_if.slave bus
);
  localparam logic [RAM_ADDR_BITS:0] WORDS_C = (RAM_ADDR_BITS+1)'(RAM_WORDS);

  top_state_e               state_q;
  logic [N_WIDTH-1:0]       start_q;
  logic [RAM_ADDR_BITS:0]   d_q, w_q;
  logic                     busy_q, done_q, ovf_q;
  logic [LANES-1:0]         lane_busy_q;
  logic [COUNT_WIDTH-1:0]   rdata_q;
  logic [COUNT_WIDTH-1:0]   mem_q [RAM_WORDS];

  logic [LANES-1:0]         lane_hold, lane_ovf, load_oh, grant_oh;
  logic [COUNT_WIDTH-1:0]   lane_result [LANES];
  logic [RAM_ADDR_BITS-1:0] lane_idx [LANES];
  logic                     wr_en, wr_ovf;
  logic [COUNT_WIDTH-1:0]   wr_data;
  logic [RAM_ADDR_BITS-1:0] wr_addr;
  logic [N_WIDTH-1:0]       load_n;

  assign load_n = start_q + N_WIDTH'(d_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    collatz_lane #(
      .N_WIDTH    (N_WIDTH),
      .COUNT_WIDTH(COUNT_WIDTH),
      .IDX_WIDTH  (RAM_ADDR_BITS)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load_oh[g]),
      .n       (load_n),
      .idx     (d_q[RAM_ADDR_BITS-1:0]),
      .grant   (grant_oh[g]),
      .hold    (lane_hold[g]),
      .result  (lane_result[g]),
      .idx_out (lane_idx[g]),
      .lane_ovf(lane_ovf[g])
    );
  end

  // Descending scan so the lowest-numbered idle/holding lane wins.
  always_comb begin
    load_oh  = '0;
    grant_oh = '0;
    wr_en    = 1'b0;
    wr_ovf   = 1'b0;
    wr_data  = '0;
    wr_addr  = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (!lane_busy_q[i]) load_oh = LANES'(1) << i;
      if (lane_hold[i]) begin
        grant_oh = LANES'(1) << i;
        wr_en    = 1'b1;
        wr_data  = lane_result[i];
        wr_addr  = lane_idx[i];
        wr_ovf   = lane_ovf[i];
      end
    end
    if (state_q != TOP_RUN || d_q == WORDS_C) load_oh = '0;
    if (state_q != TOP_RUN) begin
      grant_oh = '0;
      wr_en    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TOP_IDLE;
      start_q     <= '0;
      d_q         <= '0;
      w_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lane_busy_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TOP_IDLE, TOP_FINISH: begin
          state_q <= TOP_IDLE;
          if (bus.go) begin
            state_q     <= TOP_RUN;
            start_q     <= bus.start;
            d_q         <= '0;
            w_q         <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            lane_busy_q <= '0;
          end
        end
        TOP_RUN: begin
          lane_busy_q <= (lane_busy_q | load_oh) & ~grant_oh;
          if (load_oh != '0) d_q <= d_q + 1'b1;
          if (wr_en) begin
            w_q <= w_q + 1'b1;
            if (wr_ovf) ovf_q <= 1'b1;
          end
          if (w_q == WORDS_C) begin
            state_q <= TOP_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= TOP_IDLE;
      endcase
    end
  end

  // RAM survives reset; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= ({1'b0, bus.raddr} < WORDS_C) ? mem_q[bus.raddr] : '0;
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_collatz_range_multi.sv
module tb_collatz_range_multi;
  localparam int NU = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NU-1:0] rst_r, go_r;
  logic [31:0]   start_r [NU];
  logic [3:0]    raddr_r [NU];
  logic [3:0]    raddr_s [NU];
  logic [NU-1:0] busy_w, done_w, ovf_w, done_prev;
  logic [15:0]   rdata_w [NU];

  int unsigned exp_mem [NU][16];
  bit          exp_ovf [NU];
  bit          exp_valid [NU];
  int total = 0;
  int bad   = 0;
  int bc;
  bit ov;
  bit seen;

  int exp_basic [4] = '{1, 2, 8, 3};
  int exp_multi [8] = '{1, 1, 2, 8, 3, 6, 9, 17};
  int exp_busy  [4] = '{6, 9, 17, 4};
  int exp_fresh [4] = '{2, 8, 3, 6};

  // u0: 1 lane, 4 words   u1: 4 lanes, 8 words
  // u2: 2 lanes, 16 words u3: 8-bit values, 1 word
  collatz_range_multi_if #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_ADDR_BITS(2)) if0 ();
  collatz_range_multi_if #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_ADDR_BITS(3)) if1 ();
  collatz_range_multi_if #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_ADDR_BITS(4)) if2 ();
  collatz_range_multi_if #(.N_WIDTH(8),  .COUNT_WIDTH(16), .RAM_ADDR_BITS(1)) if3 ();

  collatz_range_multi #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_WORDS(4),  .RAM_ADDR_BITS(2), .LANES(1))
    u0 (.clk(clk), .reset(rst_r[0]), .bus(if0));
  collatz_range_multi #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_WORDS(8),  .RAM_ADDR_BITS(3), .LANES(4))
    u1 (.clk(clk), .reset(rst_r[1]), .bus(if1));
  collatz_range_multi #(.N_WIDTH(32), .COUNT_WIDTH(16), .RAM_WORDS(16), .RAM_ADDR_BITS(4), .LANES(2))
    u2 (.clk(clk), .reset(rst_r[2]), .bus(if2));
  collatz_range_multi #(.N_WIDTH(8),  .COUNT_WIDTH(16), .RAM_WORDS(1),  .RAM_ADDR_BITS(1), .LANES(1))
    u3 (.clk(clk), .reset(rst_r[3]), .bus(if3));

  assign if0.go = go_r[0]; assign if0.start = start_r[0];      assign if0.raddr = raddr_r[0][1:0];
  assign if1.go = go_r[1]; assign if1.start = start_r[1];      assign if1.raddr = raddr_r[1][2:0];
  assign if2.go = go_r[2]; assign if2.start = start_r[2];      assign if2.raddr = raddr_r[2];
  assign if3.go = go_r[3]; assign if3.start = start_r[3][7:0]; assign if3.raddr = raddr_r[3][0:0];

  assign busy_w = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign done_w = {if3.done, if2.done, if1.done, if0.done};
  assign ovf_w  = {if3.ovf,  if2.ovf,  if1.ovf,  if0.ovf};
  assign rdata_w[0] = if0.rdata;
  assign rdata_w[1] = if1.rdata;
  assign rdata_w[2] = if2.rdata;
  assign rdata_w[3] = if3.rdata;

  function automatic int nwords(input int u);
    case (u)
      0: return 4;
      1: return 8;
      2: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int nbits(input int u);
    return (u == 3) ? 8 : 32;
  endfunction

  // Term count from n down to 1; 0xFFFF when 3n+1 leaves nb bits.
  function automatic longint unsigned model_count(input longint unsigned n0, input int nb,
                                                  output bit ovo);
    longint unsigned n = n0;
    longint unsigned c = 1;
    ovo = 1'b0;
    while (n > 1) begin
      if (n % 2 == 0) n = n / 2;
      else begin
        n = 3 * n + 1;
        if ((n >> nb) != 0) begin
          ovo = 1'b1;
          return 64'hFFFF;
        end
      end
      if (c < 65534) c++;
    end
    return c;
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic start_run(input int u, input logic [31:0] st);
    bit o;
    @(posedge clk); #1;
    exp_valid[u] = 1'b0;
    exp_ovf[u]   = 1'b0;
    for (int j = 0; j < nwords(u); j++) begin
      exp_mem[u][j] = int'(model_count(longint'(st) + j, nbits(u), o));
      exp_ovf[u] |= o;
    end
    start_r[u] = st;
    go_r[u]    = 1'b1;
    @(posedge clk); #1;
    go_r[u]    = 1'b0;
  endtask

  task automatic wait_done(input int u, input string nm, output int busy_cyc);
    bit got = 1'b0;
    busy_cyc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_w[u]) begin
        got = 1'b1;
        break;
      end
      if (busy_w[u]) busy_cyc++;
    end
    chk({nm, "_done_seen"}, longint'(got), 1);
    if (got) exp_valid[u] = 1'b1;
  endtask

  task automatic rd(input int u, input int a, input int req, input string nm);
    @(posedge clk); #1;
    raddr_r[u] = a[3:0];
    @(posedge clk);
    @(negedge clk);
    chk(nm, longint'(rdata_w[u]), req);
  endtask

  always @(posedge clk) begin
    for (int u = 0; u < NU; u++) raddr_s[u] <= raddr_r[u];
  end

  // Cycle-by-cycle compare against the model whenever a result set is settled.
  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (!rst_r[u]) begin
        if (done_w[u]) begin
          chk($sformatf("u%0d_done_not_busy", u), longint'(busy_w[u]), 0);
          chk($sformatf("u%0d_done_one_cycle", u), longint'(done_prev[u]), 0);
        end
        if (exp_valid[u] && !busy_w[u]) begin
          if (int'(raddr_s[u]) < nwords(u))
            chk($sformatf("u%0d_rdata_model", u), longint'(rdata_w[u]),
                longint'(exp_mem[u][raddr_s[u]]));
          chk($sformatf("u%0d_ovf_model", u), longint'(ovf_w[u]), longint'(exp_ovf[u]));
        end
      end
      done_prev[u] <= done_w[u];
    end
  end

  initial begin
    rst_r = '1;
    go_r  = '0;
    for (int u = 0; u < NU; u++) begin
      start_r[u]   = '0;
      raddr_r[u]   = '0;
      exp_valid[u] = 1'b0;
      exp_ovf[u]   = 1'b0;
    end

    chk("model_27",    longint'(model_count(27, 32, ov)), 112);
    chk("model_0",     longint'(model_count(0, 32, ov)), 1);
    chk("model_9",     longint'(model_count(9, 32, ov)), 20);
    chk("model_27_n8", longint'(model_count(27, 8, ov)), 65535);
    chk("model_27_n8_ovf", longint'(ov), 1);

    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      chk($sformatf("u%0d_reset_busy", u),  longint'(busy_w[u]), 0);
      chk($sformatf("u%0d_reset_done", u),  longint'(done_w[u]), 0);
      chk($sformatf("u%0d_reset_ovf", u),   longint'(ovf_w[u]), 0);
      chk($sformatf("u%0d_reset_rdata", u), longint'(rdata_w[u]), 0);
    end
    @(posedge clk); #1;
    rst_r = '0;

    // basic run, single lane
    start_run(0, 1);
    wait_done(0, "basic", bc);
    chk("basic_busy_cycles", bc, 19);
    for (int a = 0; a < 4; a++) rd(0, a, exp_basic[a], $sformatf("basic_rd%0d", a));

    // four lanes
    start_run(1, 0);
    wait_done(1, "multi", bc);
    chk("multi_ovf", longint'(ovf_w[1]), 0);
    for (int a = 0; a < 8; a++) rd(1, a, exp_multi[a], $sformatf("multi_rd%0d", a));

    // two lanes: early contention, then a long sequence
    start_run(2, 0);
    wait_done(2, "contend", bc);
    rd(2, 1, 1, "contend_rd1");
    rd(2, 0, 1, "contend_rd0");
    rd(2, 15, 18, "contend_rd15");
    start_run(2, 27);
    wait_done(2, "long", bc);
    chk("long_busy_ge_112", longint'(bc >= 112), 1);
    rd(2, 0, 112, "long_rd0");

    // 8-bit overflow, then ovf cleared by the next go
    start_run(3, 27);
    wait_done(3, "ovf", bc);
    rd(3, 0, 65535, "ovf_rd0");
    chk("ovf_set", longint'(ovf_w[3]), 1);
    start_run(3, 1);
    chk("ovf_cleared", longint'(ovf_w[3]), 0);
    wait_done(3, "ovf2", bc);
    rd(3, 0, 1, "ovf2_rd0");

    // go while busy is ignored
    start_run(0, 5);
    repeat (3) @(posedge clk);
    #1;
    start_r[0] = 100;
    go_r[0]    = 1'b1;
    @(posedge clk); #1;
    go_r[0]    = 1'b0;
    chk("busy_still_high", longint'(busy_w[0]), 1);
    wait_done(0, "busygo", bc);
    for (int a = 0; a < 4; a++) rd(0, a, exp_busy[a], $sformatf("busygo_rd%0d", a));

    // reset mid-run
    start_run(0, 9);
    repeat (5) @(posedge clk);
    #1;
    rst_r[0] = 1'b1;
    #1;
    chk("midreset_busy", longint'(busy_w[0]), 0);
    chk("midreset_done", longint'(done_w[0]), 0);
    chk("midreset_ovf",  longint'(ovf_w[0]), 0);
    @(posedge clk); #1;
    rst_r[0] = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) seen = 1'b1;
    end
    chk("midreset_no_done", longint'(seen), 0);

    // fresh run after reset
    start_run(0, 2);
    wait_done(0, "fresh", bc);
    for (int a = 0; a < 4; a++) rd(0, a, exp_fresh[a], $sformatf("fresh_rd%0d", a));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
